key_sw_event_ctrl: RTL and testbench

//  Local-bus slave that sequences sampling of 4 keys and 3 slide switches: 2-flop sync, tick-paced

---
 rtl/key_sw_event_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_key_sw_event_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/key_sw_event_ctrl.sv
// ---------------------------------------------------------------------------
// key_sw_event_ctrl
//
// Local-bus slave that samples 4 keys and 3 slide switches. Each input passes
// a 2-flop synchroniser, then a tick-paced debouncer. Press/release/change
// transitions of the debounced values are captured into sticky write-1-to-clear
// event flags, and a masked, registered level interrupt is raised while any
// enabled flag is set.
//
// Register map (16-bit data, byte offsets):
//   0x00 KEY_STATE  RO     [3:0]      debounced key state, 1 = pressed
//   0x02 SW_STATE   RO     [2:0]      debounced switch state
//   0x04 EVT        R/W1C  [10:0]     [3:0] press, [7:4] release, [10:8] sw change
//   0x06 IRQ_EN     RW     [10:0]     per-flag interrupt mask
//   0x08 DB_CFG     RW     [DB_W-1:0] ticks an input must be stable
//
// Ports:
//   lb_clk   in   1   bus/system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   rd_en    in   1   read strobe (decoded upstream)
//   wr_en    in   1   write strobe (decoded upstream)
//   addr     in   8   byte offset within the slave
//   wdata    in   16  write data
//   rdata    out  16  read data, combinational from addr while rd_en, else 0
//   key_raw  in   4   raw keys, active-low
//   sw_raw   in   3   raw switches, active-high
//   irq      out  1   level interrupt, registered
// ---------------------------------------------------------------------------
module key_sw_event_ctrl #(
   parameter int TICK_DIV   = 1000,
   parameter int DB_W       = 4,
   parameter int DB_DEFAULT = 10
) (
   input  logic        lb_clk,
   input  logic        rst_n,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [7:0]  addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   input  logic [3:0]  key_raw,
   input  logic [2:0]  sw_raw,
   output logic        irq
);

   localparam int NLANE = 7;
   localparam int PW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [DB_W-1:0] CNT_MAX   = {DB_W{1'b1}};
   localparam logic [DB_W-1:0] CFG_RST   = DB_W'(DB_DEFAULT);
   // keys idle high (released), switches idle low
   localparam logic [6:0]      SYNC_RST  = 7'b000_1111;

   localparam logic [7:0] ADDR_KEY = 8'h00;
   localparam logic [7:0] ADDR_SW  = 8'h02;
   localparam logic [7:0] ADDR_EVT = 8'h04;
   localparam logic [7:0] ADDR_IEN = 8'h06;
   localparam logic [7:0] ADDR_CFG = 8'h08;

   // Saturating increment of a lane's stable-tick counter.
   function automatic logic [DB_W-1:0] sat_inc(input logic [DB_W-1:0] v);
      logic [DB_W-1:0] r;
      if (v == CNT_MAX) begin
         r = v;
      end else begin
         r = v + {{(DB_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   // True when this tick completes the required stable period. Evaluated one
   // bit wider so a saturated counter cannot wrap in the comparison; a
   // threshold of 0 or 1 therefore accepts on the first differing tick.
   function automatic logic db_done(input logic [DB_W-1:0] cnt,
                                    input logic [DB_W-1:0] cfg);
      logic [DB_W:0] inc;
      inc = {1'b0, cnt} + {{DB_W{1'b0}}, 1'b1};
      return (inc >= {1'b0, cfg});
   endfunction

   // ------------------------------------------------------------------------
   // state
   // ------------------------------------------------------------------------
   logic [PW-1:0]               presc_r;
   logic                        tick_s;
   logic [NLANE-1:0]            sync1_r;
   logic [NLANE-1:0]            sync2_r;
   logic [NLANE-1:0]            lane_in_s;
   logic [NLANE-1:0]            deb_r;
   logic [NLANE-1:0]            deb_nxt_s;
   logic [NLANE-1:0]            chg_s;
   logic [NLANE-1:0][DB_W-1:0]  cnt_r;
   logic [NLANE-1:0][DB_W-1:0]  cnt_nxt_s;
   logic [10:0]                 evt_r;
   logic [10:0]                 evt_set_s;
   logic [10:0]                 evt_clr_s;
   logic [10:0]                 evt_nxt_s;
   logic [10:0]                 irq_en_r;
   logic [DB_W-1:0]             db_cfg_r;
   logic                        irq_r;
   logic                        wr_evt_s;
   logic                        wr_ien_s;
   logic                        wr_cfg_s;
   logic                        unused_wdata_s;

   // Upper write-data bits have no backing storage in any register.
   assign unused_wdata_s = ^wdata[15:11];

   // ------------------------------------------------------------------------
   // prescaler: tick is high for the one cycle in which the count wraps
   // ------------------------------------------------------------------------
   assign tick_s = (presc_r == PRESC_MAX);

   // Free-running debounce tick prescaler.
   always_ff @(posedge lb_clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= {PW{1'b0}};
      end else if (tick_s) begin
         presc_r <= {PW{1'b0}};
      end else begin
         presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
      end
   end

   // ------------------------------------------------------------------------
   // synchroniser; lanes [3:0] keys, [6:4] switches
   // ------------------------------------------------------------------------
   // Two-flop synchroniser for all seven raw inputs.
   always_ff @(posedge lb_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= SYNC_RST;
         sync2_r <= SYNC_RST;
      end else begin
         sync1_r <= {sw_raw, key_raw};
         sync2_r <= sync1_r;
      end
   end

   // keys are active-low on the pins; internally 1 means pressed
   assign lane_in_s = {sync2_r[6:4], ~sync2_r[3:0]};

   // ------------------------------------------------------------------------
   // per-lane debounce
   // ------------------------------------------------------------------------
   // Next debounced value, stable counter and accept strobe for every lane.
   always_comb begin
      deb_nxt_s = deb_r;
      cnt_nxt_s = cnt_r;
      chg_s     = {NLANE{1'b0}};
      for (int i = 0; i < NLANE; i++) begin
         if (!tick_s) begin
            cnt_nxt_s[i] = cnt_r[i];
         end else if (lane_in_s[i] == deb_r[i]) begin
            // input back at the accepted level: any progress is discarded
            cnt_nxt_s[i] = {DB_W{1'b0}};
         end else if (db_done(cnt_r[i], db_cfg_r)) begin
            deb_nxt_s[i] = lane_in_s[i];
            cnt_nxt_s[i] = {DB_W{1'b0}};
            chg_s[i]     = 1'b1;
         end else begin
            cnt_nxt_s[i] = sat_inc(cnt_r[i]);
         end
      end
   end

   // Debounced state and stable-tick counters.
   always_ff @(posedge lb_clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_r <= {NLANE{1'b0}};
         cnt_r <= '0;
      end else begin
         deb_r <= deb_nxt_s;
         cnt_r <= cnt_nxt_s;
      end
   end

   // ------------------------------------------------------------------------
   // events and bus writes
   // ------------------------------------------------------------------------
   // press = key accepted as 1, release = key accepted as 0, sw = any change
   assign evt_set_s = {chg_s[6:4],
                       chg_s[3:0] & ~deb_nxt_s[3:0],
                       chg_s[3:0] &  deb_nxt_s[3:0]};

   assign wr_evt_s = wr_en && (addr == ADDR_EVT);
   assign wr_ien_s = wr_en && (addr == ADDR_IEN);
   assign wr_cfg_s = wr_en && (addr == ADDR_CFG);

   // Write-1-to-clear mask for the event flags.
   always_comb begin
      if (wr_evt_s) begin
         evt_clr_s = wdata[10:0];
      end else begin
         evt_clr_s = 11'h000;
      end
   end

   // a set in the same cycle as its clear survives, so no event is lost
   assign evt_nxt_s = (evt_r & ~evt_clr_s) | evt_set_s;

   // Event flags and the registered, masked interrupt.
   always_ff @(posedge lb_clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_r <= 11'h000;
         irq_r <= 1'b0;
      end else begin
         evt_r <= evt_nxt_s;
         irq_r <= |(evt_nxt_s & irq_en_r);
      end
   end

   // Software-writable configuration registers.
   always_ff @(posedge lb_clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en_r <= 11'h000;
         db_cfg_r <= CFG_RST;
      end else begin
         if (wr_ien_s) begin
            irq_en_r <= wdata[10:0];
         end else begin
            irq_en_r <= irq_en_r;
         end
         // new threshold is seen by in-flight counters from the next tick
         if (wr_cfg_s) begin
            db_cfg_r <= wdata[DB_W-1:0];
         end else begin
            db_cfg_r <= db_cfg_r;
         end
      end
   end

   assign irq = irq_r;

   // ------------------------------------------------------------------------
   // read mux; reads have no side effects
   // ------------------------------------------------------------------------
   // Combinational read data, zero when not selected or unmapped.
   always_comb begin
      rdata = 16'h0000;
      if (rd_en) begin
         case (addr)
            ADDR_KEY: rdata = {12'h000, deb_r[3:0]};
            ADDR_SW:  rdata = {13'h0000, deb_r[6:4]};
            ADDR_EVT: rdata = {5'h00, evt_r};
            ADDR_IEN: rdata = {5'h00, irq_en_r};
            ADDR_CFG: rdata = 16'(db_cfg_r);
            default:  rdata = 16'h0000;
         endcase
      end else begin
         rdata = 16'h0000;
      end
   end

endmodule

// File: tb/tb_key_sw_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_sw_event_ctrl
//
// Directed bench for key_sw_event_ctrl with TICK_DIV=4. Ticks occur at the
// rising edges where the local cycle count (edges since reset release) is a
// multiple of 4, so stimulus can be placed exactly relative to ticks.
// ---------------------------------------------------------------------------
module tb_key_sw_event_ctrl;

   logic        lb_clk;
   logic        rst_n;
   logic        rd_en;
   logic        wr_en;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic [3:0]  key_raw;
   logic [2:0]  sw_raw;
   logic        irq;

   int total;
   int bad;
   int cyc;

   key_sw_event_ctrl #(
      .TICK_DIV   (4),
      .DB_W       (4),
      .DB_DEFAULT (10)
   ) dut (
      .lb_clk  (lb_clk),
      .rst_n   (rst_n),
      .rd_en   (rd_en),
      .wr_en   (wr_en),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .key_raw (key_raw),
      .sw_raw  (sw_raw),
      .irq     (irq)
   );

   initial lb_clk = 1'b0;
   always #5 lb_clk = ~lb_clk;

   // rising edges since reset release
   always @(posedge lb_clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [7:0] a, input logic [15:0] exp);
      logic [15:0] d;
      rd_en = 1'b1;
      addr  = a;
      #1;
      d     = rdata;
      rd_en = 1'b0;
      check(tag, d, exp);
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      wr_en = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge lb_clk);
      wr_en = 1'b0;
      wdata = 16'h0000;
   endtask

   // leave the bench at the negedge just after a tick edge
   task automatic tick_start();
      while (((cyc + 1) % 4) != 0) @(negedge lb_clk);
      @(negedge lb_clk);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst_n   = 1'b0;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      addr    = 8'h00;
      wdata   = 16'h0000;
      key_raw = 4'h0;
      sw_raw  = 3'h0;

      // ---- reset values, all keys held pressed ----
      repeat (3) @(negedge lb_clk);
      check("rst_irq", {15'h0, irq}, 16'h0000);
      chk_reg("rst_key", 8'h00, 16'h0000);
      chk_reg("rst_sw",  8'h02, 16'h0000);
      chk_reg("rst_evt", 8'h04, 16'h0000);
      chk_reg("rst_ien", 8'h06, 16'h0000);
      chk_reg("rst_cfg", 8'h08, 16'h000A);
      rst_n = 1'b1;
      repeat (5) @(negedge lb_clk);
      chk_reg("early_key", 8'h00, 16'h0000);
      key_raw = 4'hF;
      wr(8'h08, 16'h0003);
      repeat (16) @(negedge lb_clk);
      chk_reg("cfg_rb", 8'h08, 16'h0003);
      chk_reg("idle_evt", 8'h04, 16'h0000);

      // ---- register access boundaries ----
      wr(8'h00, 16'hFFFF);
      chk_reg("ro_key", 8'h00, 16'h0000);
      wr(8'h06, 16'hFFFF);
      chk_reg("ien_mask", 8'h06, 16'h07FF);
      check("ien_noevt_irq", {15'h0, irq}, 16'h0000);
      wr(8'h06, 16'h0000);
      wr(8'h08, 16'hFFFF);
      chk_reg("cfg_mask", 8'h08, 16'h000F);
      wr(8'h08, 16'h0003);
      chk_reg("unmapped", 8'h0A, 16'h0000);

      // ---- press / release key0, exact acceptance tick ----
      tick_start();
      key_raw[0] = 1'b0;
      repeat (11) @(negedge lb_clk);
      chk_reg("press_pre_key", 8'h00, 16'h0000);
      chk_reg("press_pre_evt", 8'h04, 16'h0000);
      @(negedge lb_clk);
      chk_reg("press_key", 8'h00, 16'h0001);
      chk_reg("press_evt", 8'h04, 16'h0001);
      check("press_irq_masked", {15'h0, irq}, 16'h0000);
      tick_start();
      key_raw[0] = 1'b1;
      repeat (11) @(negedge lb_clk);
      chk_reg("rel_pre_key", 8'h00, 16'h0001);
      @(negedge lb_clk);
      chk_reg("rel_key", 8'h00, 16'h0000);
      chk_reg("rel_evt", 8'h04, 16'h0011);
      wr(8'h04, 16'h0001);
      chk_reg("w1c_partial", 8'h04, 16'h0010);
      wr(8'h04, 16'h0010);
      chk_reg("w1c_rest", 8'h04, 16'h0000);

      // ---- bounce on key1: 2-tick half periods never reach 3 ticks ----
      tick_start();
      for (int i = 0; i < 10; i++) begin
         key_raw[1] = ~key_raw[1];
         repeat (8) @(negedge lb_clk);
      end
      chk_reg("bounce_key", 8'h00, 16'h0000);
      chk_reg("bounce_evt", 8'h04, 16'h0000);
      key_raw[1] = 1'b0;
      repeat (64) @(negedge lb_clk);
      chk_reg("settle_key", 8'h00, 16'h0002);
      chk_reg("settle_evt", 8'h04, 16'h0002);
      key_raw[1] = 1'b1;
      repeat (64) @(negedge lb_clk);
      chk_reg("settle_rel_evt", 8'h04, 16'h0022);
      wr(8'h04, 16'h07FF);

      // ---- interrupt ----
      wr(8'h06, 16'h0001);
      tick_start();
      key_raw[0] = 1'b0;
      repeat (11) @(negedge lb_clk);
      check("irq_pre", {15'h0, irq}, 16'h0000);
      @(negedge lb_clk);
      check("irq_set", {15'h0, irq}, 16'h0001);
      wr(8'h04, 16'h0001);
      check("irq_clr", {15'h0, irq}, 16'h0000);
      chk_reg("irq_clr_evt", 8'h04, 16'h0000);
      key_raw[0] = 1'b1;
      repeat (64) @(negedge lb_clk);
      chk_reg("irq_rel_evt", 8'h04, 16'h0010);
      check("irq_masked_rel", {15'h0, irq}, 16'h0000);
      wr(8'h04, 16'h07FF);
      wr(8'h06, 16'h0000);

      // ---- W1C colliding with a switch change event ----
      tick_start();
      sw_raw[0] = 1'b1;
      repeat (11) @(negedge lb_clk);
      wr(8'h04, 16'h0100);
      chk_reg("coll_sw", 8'h02, 16'h0001);
      chk_reg("coll_evt", 8'h04, 16'h0100);
      wr(8'h04, 16'h0100);
      chk_reg("coll_clr", 8'h04, 16'h0000);
      sw_raw[0] = 1'b0;
      repeat (64) @(negedge lb_clk);
      chk_reg("sw_fall_state", 8'h02, 16'h0000);
      chk_reg("sw_fall_evt", 8'h04, 16'h0100);
      wr(8'h04, 16'h07FF);

      // ---- async reset with key2 two ticks into its count ----
      tick_start();
      key_raw[2] = 1'b0;
      repeat (9) @(negedge lb_clk);
      rst_n = 1'b0;
      @(negedge lb_clk);
      chk_reg("mid_rst_evt", 8'h04, 16'h0000);
      chk_reg("mid_rst_cfg", 8'h08, 16'h000A);
      rst_n = 1'b1;
      repeat (39) @(negedge lb_clk);
      chk_reg("restart_pre_key", 8'h00, 16'h0000);
      chk_reg("restart_pre_evt", 8'h04, 16'h0000);
      @(negedge lb_clk);
      chk_reg("restart_key", 8'h00, 16'h0004);
      chk_reg("restart_evt", 8'h04, 16'h0004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
